// File: rtl/jt900h_prefetch.sv
// Purpose : instruction prefetch byte queue; reads 16-bit LE words, presents the next 4 opcode bytes.
// Latency : pc_ld at edge N -> mem_rd at N+1; op/op_ok/pc are combinational from queue state.
// Backpressure: reads are issued only while free space >= 2; mem_rd is held until mem_ok.
//
// Ports:
//   clk, rst (sync, active low), cen (clock enable for all state)
//   pc_ld/pc_new : flush queue and restart fetching at pc_new (any alignment)
//   fetched      : bytes consumed by the control unit this cycle (0..3)
//   op/op_ok/pc  : next 4 bytes (op[7:0] oldest), level>=4, address of op[7:0]
//   mem_addr/mem_rd/mem_din/mem_ok : word read bus (mem_addr bit0 always 0)
//   fetch_err    : sticky consume-underflow flag
// Optional checker: define JT900H_PREFETCH_CHK_EN to build the fetch_err logic;
// otherwise fetch_err is tied low. Underflow clamping is identical in both builds.

module jt900h_prefetch #(
   parameter int QW = 8,
   parameter int AW = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          pc_ld,
   input  logic [AW-1:0] pc_new,
   input  logic [1:0]    fetched,
   output logic [31:0]   op,
   output logic          op_ok,
   output logic [AW-1:0] pc,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   input  logic [15:0]   mem_din,
   input  logic          mem_ok,
   output logic          fetch_err
);

   localparam int PW = $clog2(QW);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t          st_q, st_d;
   logic [7:0]      buf_q [QW];
   logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic [LW-1:0]   lvl_q, lvl_d;
   logic [AW-1:0]   pc_q, pc_d, fa_q, fa_d, ma_q, ma_d;

   logic            we0, we1;
   logic [7:0]      wd0;
   logic [PW-1:0]   wa1;
   logic [LW-1:0]   fet_w, pop_n, push_n;
   logic            go_idle;

   assign fet_w = LW'(fetched);
   assign wa1   = wr_q + PW'(1);

   always_comb begin
      st_d    = st_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      lvl_d   = lvl_q;
      pc_d    = pc_q;
      fa_d    = fa_q;
      ma_d    = ma_q;
      we0     = 1'b0;
      we1     = 1'b0;
      wd0     = mem_din[7:0];
      pop_n   = '0;
      push_n  = '0;
      go_idle = 1'b0;

      if (pc_ld) begin
         // Flush: consume count and any returning data are ignored this cycle.
         rd_d  = '0;
         wr_d  = '0;
         lvl_d = '0;
         pc_d  = pc_new;
         fa_d  = pc_new;
         if (st_q != IDLE && !mem_ok) st_d = DROP;
         else                         go_idle = 1'b1;
      end else begin
         // Underflow clamps the pop to what is held, but pc follows the consumer.
         pop_n = (fet_w > lvl_q) ? lvl_q : fet_w;
         pc_d  = pc_q + AW'(fetched);
         case (st_q)
            IDLE: go_idle = 1'b1;
            REQ: begin
               if (mem_ok) begin
                  go_idle = 1'b1;
                  we0     = 1'b1;
                  if (fa_q[0]) begin
                     // Odd fetch address: only the upper byte belongs to the stream.
                     wd0    = mem_din[15:8];
                     push_n = LW'(1);
                  end else begin
                     we1    = 1'b1;
                     push_n = LW'(2);
                  end
               end
            end
            DROP: if (mem_ok) go_idle = 1'b1;
            default: go_idle = 1'b1;
         endcase
         rd_d  = rd_q + PW'(pop_n);
         wr_d  = wr_q + PW'(push_n);
         lvl_d = lvl_q - pop_n + push_n;
         fa_d  = fa_q + AW'(push_n);
      end

      // Returning to IDLE re-arms immediately when there is room, so a new
      // request can follow a completed one in the same cycle.
      if (go_idle) begin
         st_d = IDLE;
         if ((LW'(QW) - lvl_d) >= LW'(2)) begin
            st_d = REQ;
            ma_d = {fa_d[AW-1:1], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q  <= IDLE;
         rd_q  <= '0;
         wr_q  <= '0;
         lvl_q <= '0;
         pc_q  <= '0;
         fa_q  <= '0;
         ma_q  <= '0;
         for (int i = 0; i < QW; i++) buf_q[i] <= '0;
      end else if (cen) begin
         st_q  <= st_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         lvl_q <= lvl_d;
         pc_q  <= pc_d;
         fa_q  <= fa_d;
         ma_q  <= ma_d;
         if (we0) buf_q[wr_q] <= wd0;
         if (we1) buf_q[wa1]  <= mem_din[15:8];
      end
   end

   assign op       = {buf_q[rd_q + PW'(3)], buf_q[rd_q + PW'(2)],
                      buf_q[rd_q + PW'(1)], buf_q[rd_q]};
   assign op_ok    = (lvl_q >= LW'(4));
   assign pc       = pc_q;
   assign mem_addr = ma_q;
   assign mem_rd   = (st_q != IDLE);

`ifdef JT900H_PREFETCH_CHK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (cen && !pc_ld && fetched != 2'd0 && (fet_w > lvl_q || !op_ok)) begin
         err_q <= 1'b1;
      end
   end

   assign fetch_err = err_q;
`else
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_jt900h_prefetch.sv
// Purpose : self-checking bench for jt900h_prefetch with a byte-queue reference model.
// Latency : model state advances on every enabled clock edge; outputs compared each negedge.
// Backpressure: bench memory answers with a programmable wait count while mem_rd is high.

module tb_jt900h_prefetch;

   localparam int QW = 8;

   logic        clk = 1'b0;
   logic        rst, cen, pc_ld;
   logic [23:0] pc_new;
   logic [1:0]  fetched;
   logic [31:0] op;
   logic        op_ok;
   logic [23:0] pc, mem_addr;
   logic        mem_rd;
   logic [15:0] mem_din;
   logic        mem_ok;
   logic        fetch_err;

   always #5 clk = ~clk;

   jt900h_prefetch #(.QW(QW), .AW(24)) dut (
      .clk(clk), .rst(rst), .cen(cen), .pc_ld(pc_ld), .pc_new(pc_new),
      .fetched(fetched), .op(op), .op_ok(op_ok), .pc(pc), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_din(mem_din), .mem_ok(mem_ok), .fetch_err(fetch_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: the queue holds exactly the bytes the DUT must hold.
   byte unsigned q[$];
   logic [23:0]  m_pc, m_fa;
   bit           m_drop, m_err, m_live;
   int           lat_cnt, lat_max;
   logic [23:0]  addr_log[$];

   function automatic logic [7:0] pat(input logic [23:0] a);
      return a[7:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("op_ok", op_ok, q.size() >= 4);
      chk("pc", pc, m_pc);
      for (int i = 0; i < 4; i++)
         if (i < q.size()) chk($sformatf("op_byte%0d", i), op[8*i +: 8], q[i]);
`ifdef JT900H_PREFETCH_CHK_EN
      chk("fetch_err", fetch_err, m_err);
`else
      chk("fetch_err", fetch_err, 1'b0);
`endif
      chk("mem_addr_lsb", mem_addr[0], 1'b0);
      if (m_drop) chk("drop_holds_rd", mem_rd, 1'b1);
      if (mem_rd && !m_drop) begin
         chk("mem_addr", mem_addr, {m_fa[23:1], 1'b0});
         chk("space_at_req", q.size() <= QW - 2, 1'b1);
      end
      if (!mem_rd && m_live) chk("idle_only_when_full", q.size() > QW - 2, 1'b1);
   endtask

   // One clock: drive inputs and memory, advance the model, then compare at negedge.
   task automatic cyc(input bit r, input bit c, input bit ld, input logic [23:0] nw,
                      input logic [1:0] f);
      bit fire;
      int lvl, n;
      rst     = r;
      cen     = c;
      pc_ld   = ld;
      pc_new  = nw;
      fetched = f;
      mem_ok  = (mem_rd === 1'b1) && (lat_cnt == 0);
      mem_din = {pat({mem_addr[23:1], 1'b1}), pat({mem_addr[23:1], 1'b0})};
      fire    = (mem_rd === 1'b1) && mem_ok;

      if (!r) begin
         q.delete();
         m_pc    = '0;
         m_fa    = '0;
         m_drop  = 1'b0;
         m_err   = 1'b0;
         m_live  = 1'b0;
         lat_cnt = $urandom_range(lat_max, 0);
      end else if (c) begin
         m_live = 1'b1;
         if (fire) lat_cnt = $urandom_range(lat_max, 0);
         else if (mem_rd === 1'b1 && lat_cnt > 0) lat_cnt--;
         if (ld) begin
            q.delete();
            m_pc   = nw;
            m_fa   = nw;
            m_drop = (mem_rd === 1'b1) && !mem_ok;
         end else begin
            lvl = q.size();
            if (f != 2'd0) begin
               if (int'(f) > lvl || lvl < 4) m_err = 1'b1;
               n = (int'(f) > lvl) ? lvl : int'(f);
               repeat (n) void'(q.pop_front());
               m_pc = m_pc + 24'(f);
            end
            if (fire) begin
               if (m_drop) begin
                  m_drop = 1'b0;
               end else begin
                  addr_log.push_back({m_fa[23:1], 1'b0});
                  if (m_fa[0]) begin
                     q.push_back(pat(m_fa));
                     m_fa = m_fa + 24'd1;
                  end else begin
                     q.push_back(pat(m_fa));
                     q.push_back(pat(m_fa + 24'd1));
                     m_fa = m_fa + 24'd2;
                  end
               end
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int k);
      repeat (k) cyc(1'b1, 1'b1, 1'b0, 24'h0, 2'd0);
   endtask

   initial begin
      rst = 1'b0; cen = 1'b1; pc_ld = 1'b0; pc_new = '0; fetched = '0;
      mem_ok = 1'b0; mem_din = '0;
      q.delete(); m_pc = '0; m_fa = '0; m_drop = 1'b0; m_err = 1'b0; m_live = 1'b0;
      lat_max = 0; lat_cnt = 0;
      @(negedge clk);

      // Reset state
      cyc(1'b0, 1'b1, 1'b0, 24'h0, 2'd0);
      cyc(1'b0, 1'b0, 1'b0, 24'h0, 2'd0);
      chk("rst_op", op, 32'h0);
      chk("rst_mem_rd", mem_rd, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_op_ok", op_ok, 1'b0);

      // 1: jump to 0x100 and fill
      addr_log.delete();
      cyc(1'b1, 1'b1, 1'b1, 24'h000100, 2'd0);
      chk("t1_mem_rd_n1", mem_rd, 1'b1);
      idle(8);
      chk("t1_nreads", addr_log.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < addr_log.size()) chk($sformatf("t1_addr%0d", i), addr_log[i], 32'h100 + 2*i);
      chk("t1_op", op, 32'h03020100);
      chk("t1_pc", pc, 32'h100);
      chk("t1_mem_rd_off", mem_rd, 1'b0);

      // 2: consume 3
      addr_log.delete();
      cyc(1'b1, 1'b1, 1'b0, 24'h0, 2'd3);
      chk("t2_op", op, 32'h06050403);
      chk("t2_pc", pc, 32'h103);
      idle(4);
      chk("t2_nreads", addr_log.size(), 1);
      if (addr_log.size() > 0) chk("t2_addr", addr_log[0], 32'h108);

      // 3: odd target
      addr_log.delete();
      cyc(1'b1, 1'b1, 1'b1, 24'h000201, 2'd0);
      idle(8);
      if (addr_log.size() > 0) chk("t3_addr", addr_log[0], 32'h200);
      chk("t3_op", op, 32'h04030201);
      chk("t3_pc", pc, 32'h201);

      // 4: jump while a read is stalled
      lat_cnt = 3;
      cyc(1'b1, 1'b1, 1'b1, 24'h000300, 2'd0);
      chk("t4_req", mem_rd, 1'b1);
      addr_log.delete();
      cyc(1'b1, 1'b1, 1'b1, 24'h000345, 2'd0);
      chk("t4_drop_rd", mem_rd, 1'b1);
      idle(10);
      if (addr_log.size() > 0) chk("t4_first_addr", addr_log[0], 32'h344);
      chk("t4_op", op, 32'h48474645);
      chk("t4_pc", pc, 32'h345);

      // 5: steady 2-byte consumption, 64 bytes
      cyc(1'b1, 1'b1, 1'b1, 24'h000400, 2'd0);
      idle(6);
      repeat (32) cyc(1'b1, 1'b1, 1'b0, 24'h0, 2'd2);
      chk("t5_pc", pc, 32'h440);
      chk("t5_op_ok", op_ok, 1'b1);
      chk("t5_no_err", fetch_err, 1'b0);

      // 6: underflow right after a jump
      cyc(1'b1, 1'b1, 1'b1, 24'h000500, 2'd0);
      cyc(1'b1, 1'b1, 1'b0, 24'h0, 2'd1);
      chk("t6_pc", pc, 32'h501);
      idle(3);
`ifdef JT900H_PREFETCH_CHK_EN
      chk("t6_err_held", fetch_err, 1'b1);
`else
      chk("t6_err_off", fetch_err, 1'b0);
`endif
      cyc(1'b0, 1'b1, 1'b0, 24'h0, 2'd0);
      chk("t6_err_rst", fetch_err, 1'b0);

      // Randomized traffic
      lat_max = 2;
      for (int i = 0; i < 3000; i++) begin
         bit          r, c, ld;
         logic [1:0]  f;
         r  = ($urandom_range(299, 0) != 0);
         c  = ($urandom_range(9, 0) != 0);
         ld = ($urandom_range(39, 0) == 0);
         if (q.size() >= 3 && $urandom_range(1, 0) == 1) f = 2'($urandom_range(3, 0));
         else if ($urandom_range(19, 0) == 0)            f = 2'($urandom_range(3, 0));
         else                                             f = 2'd0;
         cyc(r, c, ld, 24'($urandom), f);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
